// File: rtl/aucohl_fifo_reader_pkg.sv
// Shared types for the aucohl FIFO burst reader: FSM state encoding and
// the depth of the output skid buffer.
package aucohl_fifo_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Number of words the output skid buffer can hold.
    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/aucohl_fifo_reader_if.sv
// FIFO read port plus valid/ready output stream of the burst reader.
// master: the reader side; slave: the FIFO and the downstream consumer.
interface aucohl_fifo_reader_if #(
    parameter int DW = 8
);
    logic          fifo_empty;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_rd;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;

    modport master (
        input  fifo_empty, fifo_rdata, m_ready,
        output fifo_rd, m_valid, m_data, m_last
    );

    modport slave (
        output fifo_empty, fifo_rdata, m_ready,
        input  fifo_rd, m_valid, m_data, m_last
    );
endinterface

// File: rtl/aucohl_skid2.sv
// Two-entry skid buffer. e0 is the head presented downstream; e1 catches
// the word popped from the FIFO while the head is stalled.
module aucohl_skid2 #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [1:0]   cnt,
    output logic [W-1:0] dout
);

    logic [W-1:0] e0;
    logic [W-1:0] e1;

    // Fill, shift or replace the entries depending on push/pop this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the entries are reset because e0 drives m_data directly,
            // which must read zero out of reset.
            cnt <= 2'd0;
            e0  <= '0;
            e1  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every entry update sees the
            // pre-edge values of cnt, e0 and e1.
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) e0 <= din;
                    else             e1 <= din;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    e0  <= e1;
                    cnt <= cnt - 2'd1;
                end
                // Simultaneous push/pop only happens with one entry held.
                2'b11:   e0 <= din;
                default: ;
            endcase
        end
    end

    assign dout = e0;

endmodule

// File: rtl/aucohl_fifo_reader.sv
// Drains burst_len words from a show-ahead FIFO into a valid/ready stream,
// flags the final word with m_last and pulses done once it is accepted.
module aucohl_fifo_reader
    import aucohl_fifo_reader_pkg::*;
#(
    parameter int DW = 8,
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [BW-1:0] burst_len,
    output logic          busy,
    output logic          done,
    aucohl_fifo_reader_if.master bus
);

    state_t        state;
    logic [BW-1:0] rem;
    logic [1:0]    cnt;
    logic [DW:0]   skid_dout;
    logic          last_word;
    logic          beat;

    // The word being popped now is the last of the burst.
    assign last_word = (rem == BW'(1));

    // Pop decision uses only registered state, never m_ready.
    assign bus.fifo_rd = (state == RUN) && !bus.fifo_empty && (cnt < 2'(SKID_DEPTH));

    assign bus.m_valid = (cnt != 2'd0);
    assign beat        = bus.m_valid && bus.m_ready;
    assign {bus.m_data, bus.m_last} = skid_dout;

    aucohl_skid2 #(
        .W (DW + 1)
    ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .push (bus.fifo_rd),
        .din  ({bus.fifo_rdata, last_word}),
        .pop  (beat),
        .cnt  (cnt),
        .dout (skid_dout)
    );

    // Burst control FSM with the remaining-word counter and registered busy/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rem   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rem   <= burst_len;
                        busy  <= 1'b1;
                        state <= (burst_len != '0) ? RUN : FLUSH;
                    end
                end
                RUN: begin
                    if (bus.fifo_rd) begin
                        if (rem != '0) rem <= rem - BW'(1);
                        if (last_word) state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (cnt == 2'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
